ucomb_array: RTL and testbench
==============================

# ucomb_array

Parametrised, sequential array of universal LUT gates. Each of LANES lanes evaluates an arbitrary K-input boolean function. The function tables are loaded once over a serial configuration port. Evaluation is registered and uses a valid handshake. A built-in reference path checks every evaluation: it computes each lane by direct table indexing, and a sticky flag plus a saturating counter record any disagreement. The block is the next-generation test/characterisation wrapper for the universal-gate cells: it replaces the fixed 2/3/4-input combinational set with a configurable, self-checking bank.

## Interface
Parameters:
- LANES, 4, number of independent LUT lanes (1..16)
- K, 3, inputs per lane (2..4); each table is 2^K bits
- CNT_W, 8, width of err_count

Derived constant:
- CFG_W = LANES*2^K, total configuration bits

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- cfg_start  in  1  one-cycle pulse: clear all tables, enter LOAD
- cfg_valid  in  1  cfg_bit is valid this cycle
- cfg_bit  in  1  serial configuration bit
- cfg_done  out  1  high while in RUN
- in_valid  in  1  in_data valid this cycle
- in_data  in  LANES*K  lane L inputs at [L*K +: K]
- inj_fault  in  1  debug only: inverts the main-path output of lane 0
- out_valid  out  1  out_data valid
- out_data  out  LANES  bit L = lane L result
- mismatch  out  1  sticky: the main and reference paths disagreed
- err_count  out  CNT_W  number of mismatching evaluations, saturating
- state  out  2  current FSM state encoding

## Operation
- FSM states:
  - UNCFG=0
  - LOAD=1
  - RUN=2
  - encoding 3 is unused; if entered, the next state is UNCFG
- Transitions:
  - UNCFG→LOAD on cfg_start.
  - LOAD→RUN on the cycle the CFG_W-th bit is accepted.
  - RUN→LOAD on cfg_start.
  - cfg_start in LOAD restarts the load: tables cleared, bit counter set to 0.
- Load rules:
  - A bit is accepted when cfg_valid=1 and cfg_start=0 in LOAD.
  - The n-th accepted bit (n from 0) is written to table bit n mod 2^K of lane n div 2^K, LSB first.
  - cfg_valid is ignored in UNCFG and RUN.
  - If cfg_start and cfg_valid are high in the same cycle, cfg_start wins and the bit is dropped.
- Evaluation is active only in RUN:
  - For each accepted in_valid, lane L outputs table_L[in_data[L*K +: K]].
  - The main path is a binary mux tree of 2:1 universal cells.
  - The reference path indexes the table directly.
  - in_valid is ignored outside RUN.
- Check rules:
  - Each evaluation whose main and reference vectors differ sets mismatch and increments err_count once per cycle, regardless of how many lanes differ.
  - err_count saturates at 2^CNT_W−1.
  - mismatch and err_count clear only on reset or cfg_start.
- out_data always carries the main-path result. The reference result is not output.

## Timing
- Reset (rst_n=0 at an edge):
  - state=UNCFG
  - all tables=0, bit counter=0
  - out_valid=0, out_data=0
  - cfg_done=0
  - mismatch=0, err_count=0
- Evaluation latency is 1 cycle: in_valid sampled at edge t gives out_valid=1 and out_data registered at edge t, visible during cycle t+1.
- out_valid is 0 in any cycle with no accepted input. out_data holds its last value when out_valid=0.
- cfg_done rises in the cycle after the last configuration bit is accepted. In RUN, in_valid is accepted from that cycle on.
- cfg_start in RUN:
  - the next cycle is in LOAD, with out_valid=0 and cfg_done=0
  - an in_valid in the same cycle as cfg_start is dropped
- Reset mid-load or mid-run discards all state. No partial table survives.
- mismatch and err_count update in the same edge as out_valid.

## Structure
- Shared package ucomb_pkg holds:
  - the state typedef (UNCFG/LOAD/RUN)
  - CFG_W as a derivation helper
  - the saturating-increment function
- Sub-module ucomb_lut (parameter K) is instantiated LANES times. It takes a 2^K-bit table and K select bits and produces one output as a log-depth tree of 2:1 universal mux cells.
- The top level holds the FSM, configuration shift/counter, output registers and checker.

## Test plan
All tests use K=3, LANES=4.

1. Reset behaviour: hold rst_n=0 for 2 cycles with random inputs → state=0 and every output is 0; in_valid is ignored.
2. Configure and evaluate:
   - Stimulus: cfg_start, then 32 bits giving tables lane0=0x96 (XOR3), lane1=0xE8 (majority), lane2=0x80 (AND3), lane3=0xFE (OR3); then in_valid with every lane input=3'b011.
   - Response: cfg_done=1 one cycle after the last bit; out_valid=1 one cycle after in_valid with out_data=4'b1010; mismatch=0.
3. Exhaustive sweep: back-to-back in_valid over all 4096 in_data values → out_valid is continuous, every output matches a bench model, and err_count=0.
4. Fault injection: inj_fault=1 for 3 valid inputs → mismatch=1 and err_count=3; with CNT_W=2 and 5 faulty inputs → err_count=3 (saturated).
5. Load interrupt: cfg_start after 10 bits, then 32 new bits → only the new tables take effect; a cfg_bit sent together with cfg_start is dropped.
6. Reconfigure in RUN: cfg_start together with in_valid → no out_valid follows, state=LOAD, mismatch and err_count are cleared, and the table contents read back as 0 via evaluation after a reload of all zeros.

Source files
------------

// File: rtl/ucomb_pkg.sv
// Shared types and helpers for the universal LUT array.
// State encoding, configuration size and saturating increment.
package ucomb_pkg;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2
  } state_e;

  function automatic int cfg_w(input int lanes, input int k);
    return lanes * (1 << k);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v == top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ucomb_lut.sv
// One K-input universal gate: a 2^K-entry table selected
// through a log-depth tree of 2:1 mux cells.
module ucomb_lut #(
  parameter int K = 3
) (
  input  logic [(1<<K)-1:0] table_i,
  input  logic [K-1:0]      sel_i,
  output logic              y_o
);

  localparam int N = 1 << K;

  // Level l halves the candidates using select bit l (LSB first).
  for (genvar l = 0; l < K; l++) begin : g_lvl
    localparam int W = N >> (l + 1);
    logic [W-1:0]   v;
    logic [2*W-1:0] src;

    if (l == 0) begin : g_src0
      assign src = table_i;
    end else begin : g_srcn
      assign src = g_lvl[l-1].v;
    end

    for (genvar j = 0; j < W; j++) begin : g_cell
      assign v[j] = sel_i[l] ? src[2*j+1] : src[2*j];
    end
  end

  assign y_o = g_lvl[K-1].v[0];

endmodule

// File: rtl/ucomb_array.sv
// Self-checking bank of serially configured K-input LUT lanes
// with a mux-tree main path and a direct-index reference path.
module ucomb_array
  import ucomb_pkg::*;
#(
  parameter int LANES = 4,
  parameter int K     = 3,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_start,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_done,
  input  logic               in_valid,
  input  logic [LANES*K-1:0] in_data,
  input  logic               inj_fault,
  output logic               out_valid,
  output logic [LANES-1:0]   out_data,
  output logic               mismatch,
  output logic [CNT_W-1:0]   err_count,
  output logic [1:0]         state
);

  localparam int T     = 1 << K;
  localparam int CFG_W = cfg_w(LANES, K);
  localparam int BW    = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam logic [BW-1:0] LAST = BW'(CFG_W - 1);

  state_e             state_q;
  logic [CFG_W-1:0]   tbl_q;
  logic [BW-1:0]      bcnt_q;
  logic               done_q;
  logic               ov_q;
  logic [LANES-1:0]   od_q;
  logic               mis_q;
  logic [CNT_W-1:0]   err_q;
  logic [CNT_W-1:0]   err_d;

  logic [LANES-1:0]   raw_v;
  logic [LANES-1:0]   main_v;
  logic [LANES-1:0]   ref_v;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [T-1:0] lt;
    assign lt = tbl_q[g*T +: T];

    ucomb_lut #(.K(K)) u_lut (
      .table_i (lt),
      .sel_i   (in_data[g*K +: K]),
      .y_o     (raw_v[g])
    );

    assign ref_v[g] = lt[in_data[g*K +: K]];
  end

  always_comb begin
    main_v    = raw_v;
    main_v[0] = raw_v[0] ^ inj_fault;
  end

  assign err_d = CNT_W'(sat_inc(32'(err_q), CNT_W));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= UNCFG;
      tbl_q   <= '0;
      bcnt_q  <= '0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      mis_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      ov_q <= 1'b0;
      if (cfg_start && state_q != 2'd3) begin
        // Start wins over any bit or input in the same cycle.
        state_q <= LOAD;
        tbl_q   <= '0;
        bcnt_q  <= '0;
        done_q  <= 1'b0;
        mis_q   <= 1'b0;
        err_q   <= '0;
      end else begin
        unique case (state_q)
          UNCFG: ;
          LOAD: begin
            if (cfg_valid) begin
              tbl_q[bcnt_q] <= cfg_bit;
              bcnt_q        <= bcnt_q + 1'b1;
              if (bcnt_q == LAST) begin
                state_q <= RUN;
                done_q  <= 1'b1;
              end
            end
          end
          RUN: begin
            if (in_valid) begin
              ov_q <= 1'b1;
              od_q <= main_v;
              if (main_v != ref_v) begin
                mis_q <= 1'b1;
                err_q <= err_d;
              end
            end
          end
          default: begin
            state_q <= UNCFG;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_done  = done_q;
  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign mismatch  = mis_q;
  assign err_count = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_ucomb_array.sv
// Directed bench for ucomb_array with a behavioural model
// checked every cycle plus literal anchor checks.
module tb_ucomb_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, cfg_start, cfg_valid, cfg_bit;
  logic        in_valid, inj_fault;
  logic [11:0] in_data;

  logic        cfg_done, out_valid, mismatch;
  logic [3:0]  out_data;
  logic [7:0]  err_count;
  logic [1:0]  state;

  logic        s_done, s_ov, s_mis;
  logic [3:0]  s_od;
  logic [1:0]  s_err;
  logic [1:0]  s_state;

  ucomb_array #(.LANES(4), .K(3), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_data(in_data),
    .inj_fault(inj_fault),
    .out_valid(out_valid), .out_data(out_data),
    .mismatch(mismatch), .err_count(err_count),
    .state(state)
  );

  ucomb_array #(.LANES(4), .K(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_bit(cfg_bit), .cfg_done(s_done),
    .in_valid(in_valid), .in_data(in_data),
    .inj_fault(inj_fault),
    .out_valid(s_ov), .out_data(s_od),
    .mismatch(s_mis), .err_count(s_err),
    .state(s_state)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: tables as bytes, bits counted linearly.
  int         m_state;
  int         m_n;
  bit [7:0]   m_tbl [4];
  bit         m_ov;
  bit [3:0]   m_od;
  bit         m_mis;
  int         m_err;

  always @(posedge clk) begin
    bit [3:0] res;
    m_ov = 1'b0;
    if (!rst_n) begin
      m_state = 0;
      m_n = 0;
      for (int l = 0; l < 4; l++) m_tbl[l] = 8'h00;
      m_od = 4'h0;
      m_mis = 1'b0;
      m_err = 0;
    end else if (cfg_start) begin
      m_state = 1;
      m_n = 0;
      for (int l = 0; l < 4; l++) m_tbl[l] = 8'h00;
      m_mis = 1'b0;
      m_err = 0;
    end else if (m_state == 1 && cfg_valid) begin
      m_tbl[m_n / 8][m_n % 8] = cfg_bit;
      m_n++;
      if (m_n == 32) m_state = 2;
    end else if (m_state == 2 && in_valid) begin
      for (int l = 0; l < 4; l++)
        res[l] = m_tbl[l][in_data[l*3 +: 3]];
      if (inj_fault) begin
        res[0] = ~res[0];
        m_mis = 1'b1;
        m_err++;
      end
      m_ov = 1'b1;
      m_od = res;
    end
  end

  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_state));
    chk("cfg_done", 32'(cfg_done), 32'(m_state == 2));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_data", 32'(out_data), 32'(m_od));
    chk("mismatch", 32'(mismatch), 32'(m_mis));
    chk("err_count", 32'(err_count),
        (m_err > 255) ? 32'd255 : 32'(m_err));
    chk("err_sat", 32'(s_err),
        (m_err > 3) ? 32'd3 : 32'(m_err));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input logic [31:0] bits);
    cfg_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      cfg_bit = bits[i];
      step();
      if (i == 30) chk("done_early", 32'(cfg_done), 32'd0);
    end
    cfg_valid = 1'b0;
    chk("done_after_load", 32'(cfg_done), 32'd1);
  endtask

  task automatic eval(input logic [11:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    inj_fault = 1'b0;

    // Reset with random activity on every input.
    repeat (2) begin
      cfg_start = 1'($urandom);
      cfg_valid = 1'($urandom);
      cfg_bit   = 1'($urandom);
      in_valid  = 1'($urandom);
      in_data   = 12'($urandom);
      inj_fault = 1'($urandom);
      step();
    end
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    inj_fault = 1'b0;
    rst_n     = 1'b1;
    step();

    // XOR3, MAJ, AND3, OR3.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    load(32'hFE80E896);
    chk("state_run", 32'(state), 32'd2);
    eval(12'h6DB);
    chk("t2_valid", 32'(out_valid), 32'd1);
    chk("t2_data", 32'(out_data), 32'hA);
    chk("t2_mismatch", 32'(mismatch), 32'd0);

    // Exhaustive sweep; cfg traffic in RUN must be ignored.
    in_valid = 1'b1;
    for (int d = 0; d < 4096; d++) begin
      in_data   = 12'(d);
      cfg_valid = 1'b1;
      cfg_bit   = 1'($urandom);
      step();
    end
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    step();
    chk("sweep_err", 32'(err_count), 32'd0);

    // Fault injection and saturation.
    inj_fault = 1'b1;
    eval(12'h123);
    eval(12'h456);
    eval(12'h789);
    inj_fault = 1'b0;
    chk("inj_mismatch", 32'(mismatch), 32'd1);
    chk("inj_err3", 32'(err_count), 32'd3);
    chk("inj_sat3", 32'(s_err), 32'd3);
    inj_fault = 1'b1;
    eval(12'hABC);
    eval(12'hDEF);
    inj_fault = 1'b0;
    chk("inj_err5", 32'(err_count), 32'd5);
    chk("inj_sat5", 32'(s_err), 32'd3);

    // Interrupted load, with a bit sent alongside the restart.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    repeat (10) step();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    chk("restart_err", 32'(err_count), 32'd0);
    load(32'h0FC35A3C);
    eval(12'h000);
    chk("t5_data0", 32'(out_data), 32'hC);
    eval(12'hFFF);
    chk("t5_data7", 32'(out_data), 32'h4);

    // Reconfigure while running.
    inj_fault = 1'b1;
    eval(12'h000);
    inj_fault = 1'b0;
    chk("t6_mis_set", 32'(mismatch), 32'd1);
    cfg_start = 1'b1;
    in_valid  = 1'b1;
    in_data   = 12'h6DB;
    step();
    cfg_start = 1'b0;
    in_valid  = 1'b0;
    chk("t6_no_valid", 32'(out_valid), 32'd0);
    chk("t6_state", 32'(state), 32'd1);
    chk("t6_done", 32'(cfg_done), 32'd0);
    chk("t6_mis_clr", 32'(mismatch), 32'd0);
    chk("t6_err_clr", 32'(err_count), 32'd0);
    load(32'h00000000);
    eval(12'h6DB);
    chk("t6_zero_a", 32'(out_data), 32'h0);
    eval(12'hFFF);
    chk("t6_zero_b", 32'(out_data), 32'h0);
    chk("t6_valid", 32'(out_valid), 32'd1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
